exec_flow_unit: RTL and testbench
=================================

# exec_flow_unit

Execute-stage datapath slice of the 8-bit single-cycle processor. It contains the second-operand conditioning (negate, immediate select), the 8-bit ALU, branch/jump flow-control decision logic, and the 32-bit program counter with stall support. It sits between the register file/control unit and the instruction/data memories.

## Interface
Parameters: none. Data width is fixed at 8 bits, PC width at 32 bits.

Ports:
- CLK  in  1  system clock; the PC updates on the rising edge
- RESET  in  1  asynchronous, active-low reset
- STALL  in  1  high holds the PC; driven by the OR of the data and instruction busywait signals
- DATA1  in  8  register operand 1, used as the ALU first operand
- DATA2  in  8  register operand 2
- IMMEDIATE  in  8  instruction immediate
- SIGN_SELECT  in  1  1 = use the two's complement of DATA2
- IMM_SELECT  in  1  1 = use IMMEDIATE as the second operand
- ALUOP  in  3  ALU function select
- JUMP  in  1  unconditional jump
- BRANCH  in  1  conditional branch
- BNE  in  1  inverts the branch condition
- OFFSET  in  8  signed word offset for jump and branch
- ALURESULT  out  8  ALU result
- ZERO  out  1  high when ALURESULT == 0
- FLOW_SELECT  out  1  high when the target address is taken
- PC  out  32  current program counter

## Operation
Second operand:
- negated = ~DATA2 + 1, taken mod 256 (0x80 maps to 0x80, 0x00 maps to 0x00).
- OP2 = IMM_SELECT ? IMMEDIATE : (SIGN_SELECT ? negated : DATA2). IMM_SELECT has priority.

ALU, all results 8-bit with wrap-around:
- 000 FWD: OP2
- 001 ADD: DATA1 + OP2, mod 256
- 010 AND: DATA1 & OP2
- 011 OR: DATA1 | OP2
- 100 MUL: low 8 bits of DATA1 × OP2
- 101 SLL: DATA1 << OP2[3:0]; a shift amount of 8 or more gives 0
- 110 SRA: DATA1 arithmetic right shift by OP2[3:0]; a shift amount of 8 or more gives all copies of the sign bit
- 111 ROR: DATA1 rotated right by OP2[2:0]

Flow control:
- FLOW_SELECT = JUMP | (BRANCH & (ZERO ^ BNE)).
- beq: BRANCH=1, BNE=0, SIGN_SELECT=1, ADD. Taken when DATA1 == DATA2.
- bne: as beq with BNE=1. Taken when DATA1 != DATA2.

Next PC:
- PC_PLUS4 = PC + 4, mod 2^32.
- TARGET = PC_PLUS4 + (sign-extend(OFFSET) << 2), mod 2^32.
- NEXT = FLOW_SELECT ? TARGET : PC_PLUS4.

## Timing
- ALURESULT, ZERO and FLOW_SELECT are purely combinational from their inputs. No cycle latency and no modelled delays.
- On each rising edge of CLK: PC <= STALL ? PC : NEXT.
- RESET low forces PC = 0 immediately, independent of CLK, and holds it while RESET stays low. The first rising edge after RESET rises loads 4, unless STALL is high or a flow is taken.
- Combinational outputs are not affected by reset. With all inputs 0 after reset, ALURESULT = 0 and ZERO = 1.
- STALL and FLOW_SELECT both high: the PC holds, and the branch takes effect on the first unstalled edge, provided its inputs are still presented.
- Reset asserted during a stall: PC = 0 and the stall is ignored.
- Wrap-around: PC 0xFFFFFFFC + 4 gives 0. OFFSET 0x80 gives a displacement of -512 bytes.

## Structure
- A shared package holds:
  - ALUOP constants: ALU_FWD, ALU_ADD, ALU_AND, ALU_OR, ALU_MUL, ALU_SLL, ALU_SRA, ALU_ROR.
  - DATA_W = 8 and PC_W = 32.
- One sub-module, `alu8`: the combinational ALU producing the result and ZERO.
- Operand muxing, flow logic and the PC register stay in the top level.

## Test plan
- Reset: RESET=0 mid-cycle gives PC=0 immediately. After release with STALL=0, edges give 4, 8, 12.
- ALU sweep:
  - ADD 0x7F + 0x01 gives 0x80.
  - SUB path (SIGN_SELECT=1): 5 − 5 gives 0 with ZERO=1.
  - MUL 0x10 × 0x10 gives 0x00.
  - SRA 0x80 by 3 gives 0xF0.
  - ROR 0x01 by 1 gives 0x80.
  - SLL 0x01 by 9 gives 0x00.
- Immediate priority: IMM_SELECT=1, SIGN_SELECT=1, IMMEDIATE=0x22, FWD gives 0x22.
- Branch at PC=8 with OFFSET=0xFE:
  - beq with equal operands gives next PC 4.
  - beq with unequal operands gives 12.
  - bne inverts both outcomes.
- Jump at PC=0x10 with OFFSET=0x03 gives next PC 0x20 regardless of ZERO.
- Stall: STALL=1 for 3 edges with JUMP=1 leaves PC unchanged. On the first edge after STALL drops, PC takes the target.

Source files
------------

// File: rtl/exec_flow_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : exec_flow_unit_pkg
//  Description : Shared widths and ALU function codes for the execute-stage
//                datapath slice (operand conditioning, ALU, flow control, PC).
//  Contents    : DATA_W, PC_W, alu_op_e (ALU_FWD .. ALU_ROR)
//  Revision    : 1.0  initial release
// ============================================================================
package exec_flow_unit_pkg;

    localparam int DATA_W = 8;
    localparam int PC_W   = 32;

    typedef enum logic [2:0] {
        ALU_FWD = 3'b000,
        ALU_ADD = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_MUL = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRA = 3'b110,
        ALU_ROR = 3'b111
    } alu_op_e;

endpackage : exec_flow_unit_pkg
`default_nettype wire

// File: rtl/exec_flow_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : exec_flow_unit_if
//  Description : Bundle of operand, control and result signals between the
//                register file / control unit and the execute slice.
//  Modports    : slave  - execute slice (consumes operands, drives results)
//                master - control side (drives operands, observes results)
//  Revision    : 1.0  initial release
// ============================================================================
interface exec_flow_unit_if;
    import exec_flow_unit_pkg::*;

    logic              STALL;
    logic [DATA_W-1:0] DATA1;
    logic [DATA_W-1:0] DATA2;
    logic [DATA_W-1:0] IMMEDIATE;
    logic              SIGN_SELECT;
    logic              IMM_SELECT;
    logic [2:0]        ALUOP;
    logic              JUMP;
    logic              BRANCH;
    logic              BNE;
    logic [DATA_W-1:0] OFFSET;
    logic [DATA_W-1:0] ALURESULT;
    logic              ZERO;
    logic              FLOW_SELECT;
    logic [PC_W-1:0]   PC;

    modport slave (
        input  STALL, DATA1, DATA2, IMMEDIATE, SIGN_SELECT, IMM_SELECT,
               ALUOP, JUMP, BRANCH, BNE, OFFSET,
        output ALURESULT, ZERO, FLOW_SELECT, PC
    );

    modport master (
        output STALL, DATA1, DATA2, IMMEDIATE, SIGN_SELECT, IMM_SELECT,
               ALUOP, JUMP, BRANCH, BNE, OFFSET,
        input  ALURESULT, ZERO, FLOW_SELECT, PC
    );

endinterface : exec_flow_unit_if
`default_nettype wire

// File: rtl/exec_flow_unit_alu8.sv
`default_nettype none
// ============================================================================
//  Module      : alu8
//  Description : Purely combinational 8-bit ALU with zero flag.
//  Ports       : data1_i  - first operand
//                op2_i    - conditioned second operand
//                aluop_i  - function select
//                result_o - 8-bit result (wrap-around)
//                zero_o   - high when result_o == 0
//  Revision    : 1.0  initial release
// ============================================================================
module alu8
    import exec_flow_unit_pkg::*;
(
    input  logic [DATA_W-1:0] data1_i,
    input  logic [DATA_W-1:0] op2_i,
    input  alu_op_e           aluop_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o
);

    logic [DATA_W-1:0] w_result;
    logic [DATA_W-1:0] w_ror;

    // Rotate built from two shifts; with a zero amount the left shift by 8
    // clears all bits, leaving the operand unchanged.
    assign w_ror = (data1_i >> op2_i[2:0])
                 | (data1_i << (4'd8 - {1'b0, op2_i[2:0]}));

    always_comb begin
        w_result = '0;
        case (aluop_i)
            ALU_FWD: w_result = op2_i;
            ALU_ADD: w_result = data1_i + op2_i;
            ALU_AND: w_result = data1_i & op2_i;
            ALU_OR:  w_result = data1_i | op2_i;
            ALU_MUL: w_result = data1_i * op2_i;
            // Shift amounts use 4 bits; bit 3 set means the whole byte is
            // shifted out.
            ALU_SLL: w_result = op2_i[3] ? '0 : (data1_i << op2_i[2:0]);
            ALU_SRA: w_result = op2_i[3] ? {DATA_W{data1_i[DATA_W-1]}}
                                         : DATA_W'($signed(data1_i) >>> op2_i[2:0]);
            ALU_ROR: w_result = w_ror;
            default: w_result = '0;
        endcase
    end

    assign result_o = w_result;
    assign zero_o   = (w_result == '0);

endmodule : alu8
`default_nettype wire

// File: rtl/exec_flow_unit.sv
`default_nettype none
// ============================================================================
//  Module      : exec_flow_unit
//  Description : Execute-stage slice: second-operand conditioning (negate /
//                immediate), 8-bit ALU, branch/jump decision and the 32-bit
//                program counter with stall.
//  Ports       : CLK   - clock, PC updates on rising edge
//                RESET - asynchronous active-low reset (PC -> 0)
//                bus   - exec_flow_unit_if.slave: operands, controls,
//                        ALURESULT / ZERO / FLOW_SELECT / PC
//  Revision    : 1.0  initial release
// ============================================================================
module exec_flow_unit
    import exec_flow_unit_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    exec_flow_unit_if.slave   bus
);

    logic [DATA_W-1:0] w_negated;
    logic [DATA_W-1:0] w_op2;
    logic [DATA_W-1:0] w_result;
    logic              w_zero;
    logic              w_flow;
    logic [PC_W-1:0]   w_pc_plus4;
    logic [PC_W-1:0]   w_target;
    logic [PC_W-1:0]   pc_d;
    logic [PC_W-1:0]   pc_q;

    // Two's complement mod 256: 0x80 and 0x00 map to themselves.
    assign w_negated = ~bus.DATA2 + 8'd1;

    // Immediate select wins over the negate path.
    assign w_op2 = bus.IMM_SELECT  ? bus.IMMEDIATE :
                   bus.SIGN_SELECT ? w_negated     : bus.DATA2;

    alu8 u_alu8 (
        .data1_i  (bus.DATA1),
        .op2_i    (w_op2),
        .aluop_i  (alu_op_e'(bus.ALUOP)),
        .result_o (w_result),
        .zero_o   (w_zero)
    );

    // beq/bne subtract via the negate path; ZERO then means "operands equal".
    assign w_flow = bus.JUMP | (bus.BRANCH & (w_zero ^ bus.BNE));

    // OFFSET is a signed word count; shift to bytes after sign extension.
    assign w_pc_plus4 = pc_q + 32'd4;
    assign w_target   = w_pc_plus4 + {{(PC_W-DATA_W-2){bus.OFFSET[DATA_W-1]}},
                                      bus.OFFSET, 2'b00};

    assign pc_d = bus.STALL ? pc_q : (w_flow ? w_target : w_pc_plus4);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign bus.ALURESULT   = w_result;
    assign bus.ZERO        = w_zero;
    assign bus.FLOW_SELECT = w_flow;
    assign bus.PC          = pc_q;

endmodule : exec_flow_unit
`default_nettype wire

// File: tb/tb_exec_flow_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exec_flow_unit
//  Description : Directed self-checking bench for exec_flow_unit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_exec_flow_unit;

    logic CLK;
    logic RESET;
    int   total;
    int   bad;

    exec_flow_unit_if u_if ();

    exec_flow_unit dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (u_if.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Pulse reset between edges, then step the PC to 8.
    task automatic reset_to8();
        RESET = 1'b0;
        #1;
        RESET = 1'b1;
        tick();
        tick();
    endtask

    task automatic set_ops(input logic [7:0] d1, input logic [7:0] d2,
                           input logic [2:0] op, input logic sgn);
        u_if.DATA1       = d1;
        u_if.DATA2       = d2;
        u_if.ALUOP       = op;
        u_if.SIGN_SELECT = sgn;
        u_if.IMM_SELECT  = 1'b0;
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        RESET            = 1'b0;
        u_if.STALL       = 1'b0;
        u_if.DATA1       = '0;
        u_if.DATA2       = '0;
        u_if.IMMEDIATE   = '0;
        u_if.SIGN_SELECT = 1'b0;
        u_if.IMM_SELECT  = 1'b0;
        u_if.ALUOP       = 3'b000;
        u_if.JUMP        = 1'b0;
        u_if.BRANCH      = 1'b0;
        u_if.BNE         = 1'b0;
        u_if.OFFSET      = '0;
        #1;
        chk("reset_pc", u_if.PC, 32'd0);
        chk("reset_alu", {24'd0, u_if.ALURESULT}, 32'd0);
        chk("reset_zero", {31'd0, u_if.ZERO}, 32'd1);

        // Release and count up.
        @(negedge CLK);
        RESET = 1'b1;
        tick(); chk("pc_4", u_if.PC, 32'd4);
        tick(); chk("pc_8", u_if.PC, 32'd8);
        tick(); chk("pc_12", u_if.PC, 32'd12);

        // Reset mid-cycle while stalled: immediate clear, held across an edge.
        #2;
        u_if.STALL = 1'b1;
        RESET      = 1'b0;
        #1;
        chk("async_reset", u_if.PC, 32'd0);
        tick(); chk("reset_hold_stall", u_if.PC, 32'd0);
        RESET      = 1'b1;
        u_if.STALL = 1'b0;
        tick(); chk("post_reset_4", u_if.PC, 32'd4);
        tick(); chk("post_reset_8", u_if.PC, 32'd8);

        // ALU sweep with the PC frozen.
        u_if.STALL = 1'b1;
        set_ops(8'h7F, 8'h01, 3'b001, 1'b0);
        chk("add_7f_1", {24'd0, u_if.ALURESULT}, 32'h80);
        chk("add_zero_flag", {31'd0, u_if.ZERO}, 32'd0);
        set_ops(8'h05, 8'h05, 3'b001, 1'b1);
        chk("sub_5_5", {24'd0, u_if.ALURESULT}, 32'h00);
        chk("sub_zero_flag", {31'd0, u_if.ZERO}, 32'd1);
        set_ops(8'h10, 8'h10, 3'b100, 1'b0);
        chk("mul_10_10", {24'd0, u_if.ALURESULT}, 32'h00);
        set_ops(8'h07, 8'h06, 3'b100, 1'b0);
        chk("mul_7_6", {24'd0, u_if.ALURESULT}, 32'h2A);
        set_ops(8'h80, 8'h03, 3'b110, 1'b0);
        chk("sra_80_3", {24'd0, u_if.ALURESULT}, 32'hF0);
        set_ops(8'h80, 8'h09, 3'b110, 1'b0);
        chk("sra_80_9", {24'd0, u_if.ALURESULT}, 32'hFF);
        set_ops(8'h01, 8'h01, 3'b111, 1'b0);
        chk("ror_01_1", {24'd0, u_if.ALURESULT}, 32'h80);
        set_ops(8'h81, 8'h09, 3'b111, 1'b0);
        chk("ror_81_9", {24'd0, u_if.ALURESULT}, 32'hC0);
        set_ops(8'h01, 8'h09, 3'b101, 1'b0);
        chk("sll_01_9", {24'd0, u_if.ALURESULT}, 32'h00);
        set_ops(8'h01, 8'h03, 3'b101, 1'b0);
        chk("sll_01_3", {24'd0, u_if.ALURESULT}, 32'h08);
        set_ops(8'hF0, 8'h3C, 3'b010, 1'b0);
        chk("and_f0_3c", {24'd0, u_if.ALURESULT}, 32'h30);
        set_ops(8'hF0, 8'h3C, 3'b011, 1'b0);
        chk("or_f0_3c", {24'd0, u_if.ALURESULT}, 32'hFC);
        set_ops(8'h00, 8'h80, 3'b000, 1'b1);
        chk("neg_80", {24'd0, u_if.ALURESULT}, 32'h80);
        set_ops(8'h00, 8'h05, 3'b000, 1'b1);
        u_if.IMM_SELECT = 1'b1;
        u_if.IMMEDIATE  = 8'h22;
        #1;
        chk("imm_priority", {24'd0, u_if.ALURESULT}, 32'h22);
        chk("pc_held_sweep", u_if.PC, 32'd8);

        // beq equal at PC=8, OFFSET=0xFE -> 4.
        u_if.STALL  = 1'b0;
        u_if.BRANCH = 1'b1;
        u_if.OFFSET = 8'hFE;
        set_ops(8'h07, 8'h07, 3'b001, 1'b1);
        chk("beq_eq_flow", {31'd0, u_if.FLOW_SELECT}, 32'd1);
        tick(); chk("beq_eq_pc", u_if.PC, 32'd4);

        // beq unequal at PC=8 -> 12.
        u_if.BRANCH = 1'b0;
        tick();
        chk("pc_back_8", u_if.PC, 32'd8);
        u_if.BRANCH = 1'b1;
        set_ops(8'h07, 8'h03, 3'b001, 1'b1);
        chk("beq_ne_flow", {31'd0, u_if.FLOW_SELECT}, 32'd0);
        tick(); chk("beq_ne_pc", u_if.PC, 32'd12);

        // bne equal -> 12, bne unequal -> 4.
        u_if.BRANCH = 1'b0;
        reset_to8();
        u_if.BRANCH = 1'b1;
        u_if.BNE    = 1'b1;
        set_ops(8'h07, 8'h07, 3'b001, 1'b1);
        chk("bne_eq_flow", {31'd0, u_if.FLOW_SELECT}, 32'd0);
        tick(); chk("bne_eq_pc", u_if.PC, 32'd12);
        u_if.BRANCH = 1'b0;
        reset_to8();
        u_if.BRANCH = 1'b1;
        set_ops(8'h07, 8'h03, 3'b001, 1'b1);
        chk("bne_ne_flow", {31'd0, u_if.FLOW_SELECT}, 32'd1);
        tick(); chk("bne_ne_pc", u_if.PC, 32'd4);

        // Jump at PC=0x10, OFFSET=3 -> 0x20, with ZERO low.
        u_if.BRANCH = 1'b0;
        u_if.BNE    = 1'b0;
        u_if.OFFSET = 8'h03;
        reset_to8();
        tick(); tick();
        chk("pc_10", u_if.PC, 32'h10);
        u_if.JUMP = 1'b1;
        set_ops(8'h01, 8'h01, 3'b001, 1'b0);
        chk("jump_zero_low", {31'd0, u_if.ZERO}, 32'd0);
        chk("jump_flow", {31'd0, u_if.FLOW_SELECT}, 32'd1);
        tick(); chk("jump_pc", u_if.PC, 32'h20);

        // Stall three edges with a pending jump, then release.
        u_if.STALL = 1'b1;
        tick(); tick(); tick();
        chk("stall_hold", u_if.PC, 32'h20);
        u_if.STALL = 1'b0;
        tick(); chk("stall_release", u_if.PC, 32'h30);

        // Negative displacement and 32-bit wrap.
        RESET = 1'b0;
        #1;
        RESET = 1'b1;
        u_if.OFFSET = 8'h80;
        tick(); chk("off_80", u_if.PC, 32'hFFFFFE04);
        u_if.OFFSET = 8'h7D;
        tick(); chk("to_fffffffc", u_if.PC, 32'hFFFFFFFC);
        u_if.JUMP = 1'b0;
        tick(); chk("wrap_0", u_if.PC, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_exec_flow_unit
`default_nettype wire
